matrix_inv_sequencer: RTL

//  Control FSM that sequences the 5x5 Gauss-Jordan matrix-inversion datapath. Loads the source

---
 rtl/matrix_inv_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/matrix_inv_sequencer.sv
// matrix_inv_sequencer: control FSM for an N x N Gauss-Jordan inversion datapath (load, NORM/ELIM per pivot, read-out).
// Define PIVOT_SWAP_EN to search lower rows for a nonzero pivot and issue SWAP instead of failing on a zero pivot.
module matrix_inv_sequencer #(
    parameter int N  = 5,
    parameter int AW = 5,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err_singular,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    output logic          dp_load,
    output logic [IW-1:0] dp_row,
    output logic [IW-1:0] dp_col,
    output logic [1:0]    dp_op,
    output logic [IW-1:0] dp_k,
    output logic [IW-1:0] dp_i,
    output logic          dp_valid,
    input  logic          dp_ready,
    output logic [IW-1:0] dp_probe_row,
    input  logic          dp_pivot_zero,
    output logic [AW-1:0] out_addr,
    output logic          out_valid,
    input  logic          out_ready
);
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LOAD    = 4'd1;
    localparam logic [3:0] S_CHECK   = 4'd2;
    localparam logic [3:0] S_NORM    = 4'd3;
    localparam logic [3:0] S_ELIM    = 4'd4;
    localparam logic [3:0] S_READOUT = 4'd5;
    localparam logic [3:0] S_DONE    = 4'd6;
    localparam logic [3:0] S_ERROR   = 4'd7;
`ifdef PIVOT_SWAP_EN
    localparam logic [3:0] S_SEARCH  = 4'd8;
    localparam logic [3:0] S_SWAP    = 4'd9;
`endif
    localparam logic [AW-1:0] LAST_A = AW'(N * N - 1);
    localparam logic [IW-1:0] LAST_I = IW'(N - 1);

    logic [3:0]    state;
    logic [AW-1:0] ld_cnt, o_cnt;
    logic [IW-1:0] ld_r, ld_c, k, i, last_i, nxt_i;
    logic          hs, is_swap;

    // Outputs decode from state so an async reset zeroes them immediately.
    always_comb begin
`ifdef PIVOT_SWAP_EN
        is_swap = state == S_SWAP;
        dp_probe_row = (state == S_CHECK) ? k : (state == S_SEARCH) ? i : '0;
`else
        is_swap = 1'b0;
        dp_probe_row = (state == S_CHECK) ? k : '0;
`endif
        busy = state != S_IDLE;
        done = state == S_DONE || state == S_ERROR;
        mem_rd = state == S_LOAD;
        mem_addr = mem_rd ? ld_cnt : '0;
        dp_valid = state == S_NORM || state == S_ELIM || is_swap;
        dp_op = (state == S_NORM) ? 2'd1 : (state == S_ELIM) ? 2'd2 : is_swap ? 2'd3 : 2'd0;
        dp_k = dp_valid ? k : '0;
        dp_i = (state == S_ELIM || is_swap) ? i : '0;
        out_valid = state == S_READOUT;
        out_addr = out_valid ? o_cnt : '0;
        hs = dp_valid & dp_ready;
        last_i = (k == LAST_I) ? LAST_I - 1'b1 : LAST_I;
        nxt_i = (IW'(i + 1'b1) == k) ? IW'(i + 2'd2) : IW'(i + 1'b1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            ld_cnt <= '0;
            ld_r <= '0;
            ld_c <= '0;
            k <= '0;
            i <= '0;
            o_cnt <= '0;
            err_singular <= 1'b0;
            dp_load <= 1'b0;
            dp_row <= '0;
            dp_col <= '0;
        end else begin
            dp_load <= mem_rd;
            dp_row <= mem_rd ? ld_r : '0;
            dp_col <= mem_rd ? ld_c : '0;
            case (state)
                S_IDLE: if (start) begin
                    state <= S_LOAD;
                    err_singular <= 1'b0;
                    ld_cnt <= '0;
                    ld_r <= '0;
                    ld_c <= '0;
                    k <= '0;
                    i <= '0;
                    o_cnt <= '0;
                end
                S_LOAD: if (ld_cnt == LAST_A) state <= S_CHECK;
                else begin
                    ld_cnt <= ld_cnt + 1'b1;
                    ld_c <= (ld_c == LAST_I) ? '0 : ld_c + 1'b1;
                    ld_r <= (ld_c == LAST_I) ? ld_r + 1'b1 : ld_r;
                end
`ifdef PIVOT_SWAP_EN
                S_CHECK: if (!dp_pivot_zero) state <= S_NORM;
                else if (k == LAST_I) state <= S_ERROR;
                else begin
                    state <= S_SEARCH;
                    i <= k + 1'b1;
                end
                S_SEARCH: if (!dp_pivot_zero) state <= S_SWAP;
                else if (i == LAST_I) state <= S_ERROR;
                else i <= i + 1'b1;
                S_SWAP: if (hs) state <= S_NORM;
`else
                S_CHECK: state <= dp_pivot_zero ? S_ERROR : S_NORM;
`endif
                S_NORM: if (hs) begin
                    state <= S_ELIM;
                    i <= (k == '0) ? IW'(1) : '0;
                end
                S_ELIM: if (hs) begin
                    if (i != last_i) i <= nxt_i;
                    else if (k == LAST_I) state <= S_READOUT;
                    else begin
                        k <= k + 1'b1;
                        state <= S_CHECK;
                    end
                end
                S_READOUT: if (out_ready) begin
                    if (o_cnt == LAST_A) state <= S_DONE;
                    else o_cnt <= o_cnt + 1'b1;
                end
                S_ERROR: begin
                    err_singular <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
